// File: rtl/dac_spi_receiver.sv
// Serial DAC command receiver: oversamples CS_N/LDAC_N/DIN/SCLK in the clk domain,
// decodes dual-channel 16-bit frames into double-buffered 12-bit codes, and
// transfers input registers to the outputs on LDAC_N.
`timescale 1ns/1ps
module dac_spi_receiver #(
    parameter int FRAME_BITS  = 16,
    parameter int DATA_BITS   = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dac_cs_n,
    input  logic                 dac_ldac_n,
    input  logic                 dac_din,
    input  logic                 dac_sclk,
    output logic [DATA_BITS-1:0] code_a,
    output logic [DATA_BITS-1:0] code_b,
    output logic                 active_a,
    output logic                 active_b,
    output logic [1:0]           cfg_a,
    output logic [1:0]           cfg_b,
    output logic                 frame_valid,
    output logic                 frame_error,
    output logic                 update
);

    localparam int CNT_W = $clog2(FRAME_BITS + 2);
    localparam int REG_W = DATA_BITS + 3;
    localparam int SET_W = $clog2(SYNC_STAGES + 2) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);
    // Chains plus the edge-detect register must hold real pin values before edges count.
    localparam logic [SET_W-1:0] SETTLE   = SET_W'(SYNC_STAGES + 1);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t r_state, w_state_nxt;

    logic [SYNC_STAGES-1:0] r_cs_sync, r_ldac_sync, r_sclk_sync, r_din_sync;
    logic                   r_cs_prev, r_ldac_prev, r_sclk_prev;
    logic [SET_W-1:0]       r_settle;
    logic                   r_armed;
    logic [FRAME_BITS-1:0]  r_shift;
    logic [CNT_W-1:0]       r_cnt;
    logic [REG_W-1:0]       r_in_a, r_in_b;

    logic w_cs, w_ldac, w_sclk, w_din;
    logic w_settled, w_cs_fall, w_cs_rise, w_ldac_fall, w_sclk_rise;
    logic w_start, w_end, w_good, w_bad, w_shift_en, w_xfer;
    logic [REG_W-1:0] w_word, w_in_a_nxt, w_in_b_nxt;

    assign w_cs   = r_cs_sync[SYNC_STAGES-1];
    assign w_ldac = r_ldac_sync[SYNC_STAGES-1];
    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_din  = r_din_sync[SYNC_STAGES-1];

    assign w_settled   = (r_settle == SETTLE);
    assign w_cs_fall   = r_cs_prev & ~w_cs;
    assign w_cs_rise   = ~r_cs_prev & w_cs;
    assign w_ldac_fall = w_settled & r_ldac_prev & ~w_ldac;
    assign w_sclk_rise = ~r_sclk_prev & w_sclk;

    // Matched synchronizer chains, edge-detect history and post-reset arming.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs_sync   <= '1;
            r_ldac_sync <= '1;
            r_sclk_sync <= '0;
            r_din_sync  <= '0;
            r_cs_prev   <= 1'b1;
            r_ldac_prev <= 1'b1;
            r_sclk_prev <= 1'b0;
            r_settle    <= '0;
            r_armed     <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   dac_cs_n};
            r_ldac_sync <= {r_ldac_sync[SYNC_STAGES-2:0], dac_ldac_n};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], dac_sclk};
            r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0],  dac_din};
            r_cs_prev   <= w_cs;
            r_ldac_prev <= w_ldac;
            r_sclk_prev <= w_sclk;
            if (!w_settled) begin
                r_settle <= r_settle + 1'b1;
            end
            // A frame may only start after CS_N has been seen high, so a select
            // already low when reset releases never opens a partial frame.
            if (w_settled && w_cs) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame next-state and frame-boundary decode.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_end       = 1'b0;
        w_shift_en  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_armed && w_cs_fall) begin
                    w_state_nxt = S_SHIFT;
                    w_start     = 1'b1;
                end
            end
            S_SHIFT: begin
                if (w_cs_rise) begin
                    w_state_nxt = S_IDLE;
                    w_end       = 1'b1;
                end else begin
                    w_shift_en  = w_sclk_rise;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_good = w_end & (r_cnt == CNT_FULL);
    assign w_bad  = w_end & (r_cnt != CNT_FULL);
    assign w_word = {r_shift[FRAME_BITS-2 -: 3], r_shift[DATA_BITS-1:0]};

    // Next input-register contents, so a transfer in the same cycle sees the new frame.
    always_comb begin
        w_in_a_nxt = r_in_a;
        w_in_b_nxt = r_in_b;
        if (w_good) begin
            if (r_shift[FRAME_BITS-1]) begin
                w_in_b_nxt = w_word;
            end else begin
                w_in_a_nxt = w_word;
            end
        end
    end

    // LDAC_N edge, or LDAC_N held low at the end of a good frame, triggers one transfer.
    assign w_xfer = w_ldac_fall | (w_good & ~w_ldac);

    // Shift register, bit counter, input/output registers and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift     <= '0;
            r_cnt       <= '0;
            r_in_a      <= '0;
            r_in_b      <= '0;
            code_a      <= '0;
            code_b      <= '0;
            active_a    <= 1'b0;
            active_b    <= 1'b0;
            cfg_a       <= 2'b00;
            cfg_b       <= 2'b00;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            update      <= 1'b0;
        end else begin
            frame_valid <= w_good;
            frame_error <= w_bad;
            update      <= w_xfer;
            if (w_start) begin
                r_shift <= '0;
                r_cnt   <= '0;
            end else if (w_shift_en) begin
                r_shift <= {r_shift[FRAME_BITS-2:0], w_din};
                if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            r_in_a <= w_in_a_nxt;
            r_in_b <= w_in_b_nxt;
            if (w_xfer) begin
                code_a   <= w_in_a_nxt[DATA_BITS-1:0];
                active_a <= w_in_a_nxt[DATA_BITS];
                cfg_a    <= w_in_a_nxt[DATA_BITS+2:DATA_BITS+1];
                code_b   <= w_in_b_nxt[DATA_BITS-1:0];
                active_b <= w_in_b_nxt[DATA_BITS];
                cfg_b    <= w_in_b_nxt[DATA_BITS+2:DATA_BITS+1];
            end
        end
    end

endmodule

// File: tb/tb_dac_spi_receiver.sv
// Bench for dac_spi_receiver: drives serial DAC frames and LDAC pulses, keeps a
// model of both input registers, and checks every output transfer against it.
`timescale 1ns/1ps
module tb_dac_spi_receiver;

    logic        clk = 1'b0;
    logic        rst, cs_n, ldac_n, din, sclk;
    logic [11:0] code_a, code_b;
    logic        active_a, active_b;
    logic [1:0]  cfg_a, cfg_b;
    logic        frame_valid, frame_error, update;

    typedef struct packed {
        logic [11:0] ca; logic [1:0] fa; logic aa;
        logic [11:0] cb; logic [1:0] fb; logic ab;
    } snap_t;

    int    n_vec = 0, n_err = 0;
    int    n_valid = 0, n_error = 0, n_update = 0, n_coinc = 0;
    int    obs_rd = 0;
    snap_t exp_q[$];
    snap_t obs_q[$];
    logic [14:0] m_a, m_b;
    snap_t w_snap;

    assign w_snap = '{code_a, cfg_a, active_a, code_b, cfg_b, active_b};

    dac_spi_receiver #(.FRAME_BITS(16), .DATA_BITS(12), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .dac_cs_n(cs_n), .dac_ldac_n(ldac_n),
        .dac_din(din), .dac_sclk(sclk),
        .code_a(code_a), .code_b(code_b), .active_a(active_a), .active_b(active_b),
        .cfg_a(cfg_a), .cfg_b(cfg_b),
        .frame_valid(frame_valid), .frame_error(frame_error), .update(update)
    );

    always #5 clk = ~clk;

    // Pulse monitor: counts status pulses and records the outputs at every update.
    always @(negedge clk) begin
        if (frame_valid) n_valid++;
        if (frame_error) n_error++;
        if (update) begin
            n_update++;
            obs_q.push_back(w_snap);
        end
        if (update && frame_valid) n_coinc++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic snap_t snap_of(input logic [14:0] a, input logic [14:0] b);
        return '{a[11:0], a[14:13], a[12], b[11:0], b[14:13], b[12]};
    endfunction

    task automatic shift_bits(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            din  = w[i];
            sclk = 1'b0;
            tick(4);
            sclk = 1'b1;
            tick(4);
        end
        sclk = 1'b0;
        tick(4);
    endtask

    task automatic send_frame(input logic [31:0] w, input int n);
        cs_n = 1'b0;
        tick(8);
        shift_bits(w, n);
        cs_n = 1'b1;
        tick(8);
        if (n == 16) begin
            if (w[15]) m_b = w[14:0];
            else       m_a = w[14:0];
        end
    endtask

    task automatic pulse_ldac();
        exp_q.push_back(snap_of(m_a, m_b));
        ldac_n = 1'b0;
        tick(6);
        ldac_n = 1'b1;
        tick(6);
    endtask

    task automatic check_update(input string name);
        snap_t e;
        int    t = 0;
        while (obs_q.size() <= obs_rd && t < 60) begin
            tick(1);
            t++;
        end
        n_vec++;
        e = exp_q.pop_front();
        if (obs_q.size() <= obs_rd) begin
            n_err++;
            $display("FAIL %s: no update pulse seen, required outputs %h", name, e);
        end else begin
            if (obs_q[obs_rd] !== e) begin
                n_err++;
                $display("FAIL %s: outputs %h, required %h", name, obs_q[obs_rd], e);
            end
            obs_rd++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cs_n = 1'b1; ldac_n = 1'b1; din = 1'b0; sclk = 1'b0;
        m_a = '0; m_b = '0;
        tick(3);
        n_vec++;
        if (w_snap !== '0 || frame_valid !== 1'b0 || frame_error !== 1'b0 || update !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h v%b e%b u%b, required all 0",
                     w_snap, frame_valid, frame_error, update);
        end
        rst = 1'b0;
        tick(10);
        n_vec++;
        if (n_valid + n_error + n_update !== 0) begin
            n_err++;
            $display("FAIL reset_idle_pulses: got %0d pulses, required 0", n_valid + n_error + n_update);
        end
    endtask

    task automatic test_basic_frame();
        int v0 = n_valid, u0 = n_update;
        send_frame(32'h3ABC, 16);
        n_vec++;
        if (n_valid !== v0 + 1) begin
            n_err++;
            $display("FAIL basic_valid: got %0d frame_valid pulses, required 1", n_valid - v0);
        end
        n_vec++;
        if (code_a !== 12'h000 || n_update !== u0) begin
            n_err++;
            $display("FAIL basic_before_ldac: code_a %h updates %0d, required 000 and 0", code_a, n_update - u0);
        end
        pulse_ldac();
        check_update("basic_after_ldac");
    endtask

    task automatic test_ldac_low();
        int c0, u0;
        ldac_n = 1'b0;
        exp_q.push_back(snap_of(m_a, m_b));
        tick(8);
        check_update("ldac_low_edge");
        c0 = n_coinc; u0 = n_update;
        send_frame(32'hB123, 16);
        exp_q.push_back(snap_of(m_a, m_b));
        check_update("ldac_low_frame");
        n_vec++;
        if (n_coinc !== c0 + 1 || n_update !== u0 + 1) begin
            n_err++;
            $display("FAIL ldac_low_coincide: coincident %0d updates %0d, required 1 and 1",
                     n_coinc - c0, n_update - u0);
        end
        ldac_n = 1'b1;
        tick(8);
    endtask

    task automatic test_bad_frames();
        int v0 = n_valid, e0 = n_error;
        send_frame(32'h0000_7FFF, 15);
        send_frame(32'h0001_7FFF, 17);
        n_vec++;
        if (n_error !== e0 + 2 || n_valid !== v0) begin
            n_err++;
            $display("FAIL bad_frames: errors %0d valids %0d, required 2 and 0", n_error - e0, n_valid - v0);
        end
        pulse_ldac();
        check_update("bad_frames_keep_codes");
    endtask

    task automatic test_back_to_back();
        int u0 = n_update;
        send_frame(32'h3055, 16);
        send_frame(32'hFFAA, 16);
        n_vec++;
        if (n_update !== u0) begin
            n_err++;
            $display("FAIL b2b_no_early_update: got %0d updates, required 0", n_update - u0);
        end
        pulse_ldac();
        check_update("b2b_single_update");
        n_vec++;
        if (n_update !== u0 + 1) begin
            n_err++;
            $display("FAIL b2b_update_count: got %0d updates, required 1", n_update - u0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int v0, e0, u0;
        cs_n = 1'b0;
        tick(8);
        shift_bits(32'h3A, 8);
        rst = 1'b1;
        tick(2);
        m_a = '0; m_b = '0;
        n_vec++;
        if (w_snap !== '0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got %h, required 0", w_snap);
        end
        rst = 1'b0;
        tick(2);
        v0 = n_valid; e0 = n_error; u0 = n_update;
        shift_bits(32'hBC, 8);
        cs_n = 1'b1;
        tick(10);
        n_vec++;
        if (n_valid !== v0 || n_error !== e0 || n_update !== u0) begin
            n_err++;
            $display("FAIL mid_reset_no_pulses: v%0d e%0d u%0d, required 0 0 0",
                     n_valid - v0, n_error - e0, n_update - u0);
        end
        send_frame(32'h3001, 16);
        n_vec++;
        if (n_valid !== v0 + 1) begin
            n_err++;
            $display("FAIL mid_reset_next_frame: got %0d valids, required 1", n_valid - v0);
        end
        pulse_ldac();
        check_update("mid_reset_next_update");
    endtask

    task automatic test_reset_release_cs_low();
        int v0, e0;
        v0 = n_valid; e0 = n_error;
        for (int i = 0; i < 6; i++) begin
            sclk = 1'b1; tick(4);
            sclk = 1'b0; tick(4);
        end
        rst  = 1'b1;
        tick(2);
        m_a = '0; m_b = '0;
        cs_n = 1'b0;
        tick(1);
        rst  = 1'b0;
        shift_bits(32'h5A5A, 16);
        cs_n = 1'b1;
        tick(10);
        n_vec++;
        if (n_valid !== v0 || n_error !== e0) begin
            n_err++;
            $display("FAIL release_cs_low: v%0d e%0d, required 0 0", n_valid - v0, n_error - e0);
        end
        send_frame(32'hB7FF, 16);
        n_vec++;
        if (n_valid !== v0 + 1) begin
            n_err++;
            $display("FAIL release_then_frame: got %0d valids, required 1", n_valid - v0);
        end
        pulse_ldac();
        check_update("release_then_update");
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_ldac_low();
        test_bad_frames();
        test_back_to_back();
        test_reset_mid_frame();
        test_reset_release_cs_low();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
